// File: rtl/serial_sub.sv
// Bit-serial 8-bit subtractor: one bit per clock, LSB first, eight RUN cycles
// per operation, with borrow, signed overflow and zero flags on completion.
module serial_sub (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       busy,
    output logic [7:0] diff,
    output logic       bout,
    output logic       ovf,
    output logic       zero,
    output logic       done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [7:0]  r_a_sh;
    logic [7:0]  r_b_sh;
    logic [7:0]  r_res;
    logic        r_br;
    logic [2:0]  r_cnt;
    logic        r_a7;
    logic        r_b7;

    logic [7:0]  r_diff;
    logic        r_bout;
    logic        r_ovf;
    logic        r_zero;
    logic        r_done;

    logic        w_accept;
    logic        w_finish;
    logic        w_last;
    logic        w_ai;
    logic        w_bi;
    logic        w_d;
    logic        w_br_next;
    logic [7:0]  w_res_next;

    // One full-subtractor slice operating on the current LSBs
    assign w_ai       = r_a_sh[0];
    assign w_bi       = r_b_sh[0];
    assign w_d        = w_ai ^ w_bi ^ r_br;
    assign w_br_next  = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
    assign w_res_next = {w_d, r_res[7:1]};
    assign w_last     = (r_cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = RUN;
                    w_accept     = 1'b1;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = IDLE;
                    w_finish     = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Operand shifters, borrow chain and partial result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh <= 8'h00;
            r_b_sh <= 8'h00;
            r_res  <= 8'h00;
            r_br   <= 1'b0;
            r_cnt  <= 3'd0;
            r_a7   <= 1'b0;
            r_b7   <= 1'b0;
        end else if (w_accept) begin
            r_a_sh <= a;
            r_b_sh <= b;
            r_res  <= 8'h00;
            r_br   <= 1'b0;
            r_cnt  <= 3'd0;
            r_a7   <= a[7];
            r_b7   <= b[7];
        end else if (r_state == RUN) begin
            r_a_sh <= {1'b0, r_a_sh[7:1]};
            r_b_sh <= {1'b0, r_b_sh[7:1]};
            r_res  <= w_res_next;
            r_br   <= w_br_next;
            r_cnt  <= r_cnt + 3'd1;
        end
    end

    // Result flags only change on completion; a new start leaves them intact
    always_ff @(posedge clk) begin
        if (rst) begin
            r_diff <= 8'h00;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_finish) begin
                r_diff <= w_res_next;
                r_bout <= w_br_next;
                r_ovf  <= (r_a7 != r_b7) && (w_res_next[7] != r_a7);
                r_zero <= (w_res_next == 8'h00);
            end
        end
    end

    assign busy = (r_state == RUN);
    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;
    assign zero = r_zero;
    assign done = r_done;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed vector table, randomized
// operations against an arithmetic reference, plus abort and overlap sequences.
module tb_serial_sub;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    logic       zero;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    serial_sub dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf),
        .zero  (zero),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
        logic       zero;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the operand values
    task automatic ref_sub(input logic [7:0] ra, input logic [7:0] rb,
                           output logic [7:0] rd, output logic rbo,
                           output logic rov, output logic rz);
        int u;
        int s;
        u   = int'(ra) - int'(rb);
        s   = int'($signed(ra)) - int'($signed(rb));
        rd  = 8'(u & 255);
        rbo = (ra < rb);
        rov = (s < -128) || (s > 127);
        rz  = (rd == 8'h00);
    endtask

    // Starts one operation from IDLE and checks it through completion edge N+8.
    // noise: scramble a/b/start during RUN (including the done edge).
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb,
                          input logic [7:0] ed, input logic eb,
                          input logic eo, input logic ez,
                          input logic [7:0] prev_diff, input bit noise);
        a     = ta;
        b     = tb;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("accept_busy", busy, 1'b1);
        chk("accept_done", done, 1'b0);
        chk("hold_diff", diff, prev_diff);
        for (int i = 1; i <= 7; i++) begin
            if (noise) begin
                a     = 8'($urandom);
                b     = 8'($urandom);
                start = 1'($urandom);
            end
            tick();
            chk("run_busy", busy, 1'b1);
            chk("run_done", done, 1'b0);
        end
        if (noise) start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_pulse", done, 1'b1);
        chk("done_busy", busy, 1'b0);
        chk("diff", diff, ed);
        chk("bout", bout, eb);
        chk("ovf", ovf, eo);
        chk("zero", zero, ez);
        $display("op a=%02h b=%02h -> diff=%02h bout=%0b ovf=%0b zero=%0b", ta, tb, diff, bout, ovf, zero);
    endtask

    initial begin
        logic [7:0] last_diff;
        logic [7:0] ra, rb, rd;
        logic       rbo, rov, rz;

        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'h55, 8'h55, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_diff", diff, 8'h00);
        chk("rst_bout", bout, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_zero", zero, 1'b0);
        rst = 1'b0;
        last_diff = 8'h00;

        // Directed vectors, first one accepted on the first post-reset edge
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].bout,
                   vecs[i].ovf, vecs[i].zero, last_diff, 1'b0);
            last_diff = vecs[i].diff;
            tick();
            chk("idle_done_low", done, 1'b0);
        end

        // Randomized operations, back-to-back, with noisy inputs while running
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (i == 0) begin ra = 8'h00; rb = 8'hFF; end
            if (i == 1) begin ra = 8'hFF; rb = 8'h00; end
            ref_sub(ra, rb, rd, rbo, rov, rz);
            run_op(ra, rb, rd, rbo, rov, rz, last_diff, 1'b1);
            last_diff = rd;
        end
        tick();

        // Start during RUN and on the done edge is ignored; next edge accepted
        a = 8'h10; b = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 3 || i == 8) begin
                a = 8'hFF; b = 8'h00; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (i < 8) chk("ovl_done_low", done, 1'b0);
        end
        start = 1'b0;
        chk("ovl_done", done, 1'b1);
        chk("ovl_diff", diff, 8'h0F);
        $display("overlap op a=10 b=01 -> diff=%02h", diff);
        run_op(8'h02, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 8'h0F, 1'b0);
        last_diff = 8'h01;

        // Reset aborts an operation mid-run with no done pulse
        tick();
        a = 8'h20; b = 8'h10; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_diff", diff, 8'h00);
        chk("abort_bout", bout, 1'b0);
        chk("abort_ovf", ovf, 1'b0);
        chk("abort_zero", zero, 1'b0);
        $display("reset abort -> busy=%0b diff=%02h", busy, diff);
        run_op(8'h09, 8'h0A, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        chk("final_done_low", done, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 The block SHALL expose clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL expose rst, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-003 The block SHALL expose start, input, 1, request to begin a subtraction; sampled only in IDLE.
REQ-004 The block SHALL expose a, input, 8, minuend; sampled on the edge that accepts start.
REQ-005 The block SHALL expose b, input, 8, subtrahend; sampled on the edge that accepts start.
REQ-006 The block SHALL expose busy, output, 1, high while in RUN.
REQ-007 The block SHALL expose diff, output, 8, registered result a-b, modulo 256.
REQ-008 The block SHALL expose bout, output, 1, final borrow; 1 when a<b unsigned.
REQ-009 The block SHALL expose ovf, output, 1, two's-complement overflow of a-b.
REQ-010 The block SHALL expose zero, output, 1, high when diff==0.
REQ-011 The block SHALL expose done, output, 1, one-cycle completion pulse.

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE and RUN.
REQ-013 In IDLE with start=1, the block SHALL latch a and b into shift registers, clear the borrow flop, clear the 3-bit bit counter, and enter RUN on the same edge.
REQ-014 In RUN, each edge SHALL process one bit, LSB first: d=ai^bi^br; br_next=(~ai&bi)|(~(ai^bi)&br). d SHALL be shifted into the result register from the MSB side.
REQ-015 RUN SHALL last exactly 8 edges. The 8th edge (counter==7) SHALL perform all of the following: write the complete result to diff, write bout, ovf and zero, set done=1, and return to IDLE.
REQ-016 Latency SHALL be fixed: start accepted at edge N; done and valid outputs visible after edge N+8; done is low again after edge N+9.
REQ-017 ovf SHALL equal (a[7]!=b[7]) && (diff[7]!=a[7]), using the latched operands.
REQ-018 zero SHALL be computed from the final 8-bit result.
REQ-019 diff, bout, ovf and zero SHALL hold their values until the next completion; accepting a new start SHALL NOT clear them.
REQ-020 While in RUN, start SHALL be ignored. Changes on a and b SHALL NOT affect the operation in progress.
REQ-021 start on the same edge that done is set SHALL be ignored, because the FSM is still in RUN. start on the following edge SHALL be accepted, so back-to-back operations are spaced 9 cycles apart.
REQ-022 done SHALL be high for exactly one cycle per accepted start and SHALL never be high while busy=1.

Reset
REQ-023 When rst=1 at a rising edge, the block SHALL enter IDLE and clear busy, done, diff, bout, ovf, zero, the counter, the borrow flop and the shift registers. zero SHALL reset to 0.
REQ-024 rst SHALL take priority over start and over an in-progress RUN. An operation aborted by reset SHALL produce no done pulse.
REQ-025 After rst deasserts, start SHALL be accepted on the first edge.

Verification
REQ-026 a=0x05, b=0x03, start -> after 8 edges: diff=0x02, bout=0, ovf=0, zero=0, done pulse for 1 cycle.
REQ-027 a=0x03, b=0x05 -> diff=0xFE, bout=1, ovf=0, zero=0.
REQ-028 a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1. Then a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
REQ-029 a=0x55, b=0x55 -> diff=0x00, zero=1, bout=0, ovf=0. Then a=0x00, b=0x00 -> zero=1.
REQ-030 Start 0x10-0x01; pulse start with a=0xFF, b=0x00 at RUN edge 3 and again on the done edge -> single result diff=0x0F, one done pulse. Start on the next edge is accepted.
REQ-031 Start 0x20-0x10; assert rst at RUN edge 4 -> all outputs 0, no done pulse. Then start 0x09-0x0A on the first post-reset edge -> diff=0xFF, bout=1.
